// File: rtl/display_capture_8x8.sv
// rtl/display_capture_8x8.sv - receive-side capture of the 8x8 RGB display shift-register interface
module display_capture_8x8 #(
  parameter int BITS_PER_COL = 24,
  parameter bit INVERT_DATA  = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sr_reset_n,
  input  logic        oe_n,
  input  logic        sh_cp,
  input  logic        st_cp,
  input  logic        ds,
  input  logic [7:0]  col_sel,
  input  logic [2:0]  rd_col,
  output logic [7:0]  rd_red,
  output logic [7:0]  rd_green,
  output logic [7:0]  rd_blue,
  output logic        col_valid,
  output logic [2:0]  col_idx,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        bitcnt_err,
  output logic        colsel_err,
  output logic        blank_seen
);

  localparam int          NPIN     = 13;
  localparam logic [4:0]  FULL_CNT = 5'(BITS_PER_COL);

  logic [NPIN-1:0]         pin_raw;
  logic [NPIN-1:0]         sync_q [SYNC_STAGES];
  logic [NPIN-1:0]         pin_s;
  logic                    prev_sh, prev_st;
  logic                    sh_rise, st_rise;
  logic                    srr_s, oe_s, ds_s;
  logic [7:0]              sel_s;
  logic [BITS_PER_COL-1:0] shreg;
  logic [4:0]              shcnt;
  logic [7:0]              mask;
  logic [BITS_PER_COL-1:0] mem [8];
  logic                    onehot;
  logic [2:0]              k;
  logic [7:0]              mask_set;

  assign pin_raw = {col_sel, ds, st_cp, sh_cp, oe_n, sr_reset_n};
  assign pin_s   = sync_q[SYNC_STAGES-1];
  assign srr_s   = pin_s[0];
  assign oe_s    = pin_s[1];
  assign ds_s    = pin_s[4];
  assign sel_s   = pin_s[12:5];
  assign sh_rise = pin_s[2] & ~prev_sh;
  assign st_rise = pin_s[3] & ~prev_st;

  // ds and col_sel travel through the same chain as the clocks so they stay aligned with their edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_sh <= 1'b0;
      prev_st <= 1'b0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_sh <= pin_s[2];
      prev_st <= pin_s[3];
    end
  end

  always_comb begin
    onehot = (sel_s != 8'd0) && ((sel_s & (sel_s - 8'd1)) == 8'd0);
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_s[i]) k = i[2:0];
    end
    mask_set = mask | (8'd1 << k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
      shreg      <= '0;
      shcnt      <= 5'd0;
      mask       <= 8'd0;
      rd_red     <= 8'd0;
      rd_green   <= 8'd0;
      rd_blue    <= 8'd0;
      col_valid  <= 1'b0;
      col_idx    <= 3'd0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      bitcnt_err <= 1'b0;
      colsel_err <= 1'b0;
      blank_seen <= 1'b0;
    end else begin
      col_valid  <= 1'b0;
      frame_done <= 1'b0;
      rd_red     <= mem[rd_col][BITS_PER_COL-1  -: 8];
      rd_green   <= mem[rd_col][BITS_PER_COL-9  -: 8];
      rd_blue    <= mem[rd_col][BITS_PER_COL-17 -: 8];

      if (!srr_s) begin
        shreg <= '0;
        shcnt <= 5'd0;
      end else if (sh_rise) begin
        shreg <= {shreg[BITS_PER_COL-2:0], ds_s ^ INVERT_DATA};
        shcnt <= (shcnt == 5'd31) ? 5'd31 : shcnt + 5'd1;
      end

      // Store uses the pre-shift word; a coincident shift leaves one bit already counted
      if (st_rise) begin
        shcnt <= (srr_s && sh_rise) ? 5'd1 : 5'd0;
        if (shcnt != FULL_CNT) bitcnt_err <= 1'b1;
        if (oe_s) blank_seen <= 1'b1;
        if (!onehot) begin
          colsel_err <= 1'b1;
        end else begin
          mem[k]    <= shreg;
          col_valid <= 1'b1;
          col_idx   <= k;
          if (mask_set == 8'hFF) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            mask       <= 8'd0;
          end else begin
            mask <= mask_set;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_display_capture_8x8.sv
// tb/tb_display_capture_8x8.sv - directed self-checking bench for display_capture_8x8
module tb_display_capture_8x8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sr_reset_n = 1'b1, oe_n = 1'b0, sh_cp = 1'b0, st_cp = 1'b0, ds = 1'b0;
  logic [7:0]  col_sel = 8'd0;
  logic [2:0]  rd_col = 3'd0;
  logic [7:0]  rd_red, rd_green, rd_blue;
  logic        col_valid, frame_done, bitcnt_err, colsel_err, blank_seen;
  logic [2:0]  col_idx;
  logic [15:0] frame_cnt;
  logic [7:0]  r2, g2, b2;
  logic        cv2, fd2, be2, ce2, bs2;
  logic [2:0]  ci2;
  logic [15:0] fc2;

  int cmp = 0;
  int bad = 0;
  int cv_cnt = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  display_capture_8x8 u_dut (
    .clk(clk), .rst_n(rst_n), .sr_reset_n(sr_reset_n), .oe_n(oe_n), .sh_cp(sh_cp),
    .st_cp(st_cp), .ds(ds), .col_sel(col_sel), .rd_col(rd_col),
    .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue), .col_valid(col_valid),
    .col_idx(col_idx), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .bitcnt_err(bitcnt_err), .colsel_err(colsel_err), .blank_seen(blank_seen)
  );

  display_capture_8x8 #(.INVERT_DATA(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .sr_reset_n(sr_reset_n), .oe_n(oe_n), .sh_cp(sh_cp),
    .st_cp(st_cp), .ds(ds), .col_sel(col_sel), .rd_col(rd_col),
    .rd_red(r2), .rd_green(g2), .rd_blue(b2), .col_valid(cv2),
    .col_idx(ci2), .frame_done(fd2), .frame_cnt(fc2),
    .bitcnt_err(be2), .colsel_err(ce2), .blank_seen(bs2)
  );

  always @(negedge clk) begin
    if (col_valid) cv_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    repeat (2) @(negedge clk);
    sh_cp = 1'b1;
    repeat (3) @(negedge clk);
    sh_cp = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic shift_word(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic store(input logic [7:0] sel);
    col_sel = sel;
    repeat (2) @(negedge clk);
    st_cp = 1'b1;
    repeat (3) @(negedge clk);
    st_cp = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_col(input logic [2:0] c, output logic [23:0] w, output logic [23:0] w_inv);
    rd_col = c;
    repeat (2) @(negedge clk);
    w     = {rd_red, rd_green, rd_blue};
    w_inv = {r2, g2, b2};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if ({rd_red, rd_green, rd_blue, col_valid, col_idx, frame_done, frame_cnt,
         bitcnt_err, colsel_err, blank_seen} !== 46'd0) begin
      $display("FAIL reset_outputs got %h exp 0", {rd_red, rd_green, rd_blue, col_valid, col_idx,
               frame_done, frame_cnt, bitcnt_err, colsel_err, blank_seen});
      bad++;
    end
    cmp++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [23:0] w, wi;
    int base;
    do_reset();
    base = cv_cnt;
    shift_word(24'hA53C0F, 24);
    store(8'h08);
    if (cv_cnt - base !== 1) begin $display("FAIL basic_col_valid got %0d exp 1", cv_cnt - base); bad++; end
    cmp++;
    if (col_idx !== 3'd3) begin $display("FAIL basic_col_idx got %0d exp 3", col_idx); bad++; end
    cmp++;
    if (bitcnt_err !== 1'b0 || blank_seen !== 1'b0) begin
      $display("FAIL basic_flags got bitcnt=%b blank=%b exp 0 0", bitcnt_err, blank_seen); bad++;
    end
    cmp++;
    read_col(3'd3, w, wi);
    if (w !== 24'hA53C0F) begin $display("FAIL basic_readback got %h exp a53c0f", w); bad++; end
    cmp++;
  endtask

  task automatic test_frame();
    logic [23:0] w, wi;
    int base;
    logic [2:0] order [8] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    do_reset();
    base = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      shift_word({3{5'd0, order[i]}}, 24);
      store(8'd1 << order[i]);
      if (i == 6) begin
        if (fd_cnt - base !== 0) begin $display("FAIL frame_early got %0d exp 0", fd_cnt - base); bad++; end
        cmp++;
      end
    end
    if (fd_cnt - base !== 1) begin $display("FAIL frame_done_count got %0d exp 1", fd_cnt - base); bad++; end
    cmp++;
    if (frame_cnt !== 16'd1) begin $display("FAIL frame_cnt got %0d exp 1", frame_cnt); bad++; end
    cmp++;
    for (int c = 0; c < 8; c++) begin
      read_col(c[2:0], w, wi);
      if (w !== 24'h010101 * c) begin
        $display("FAIL frame_readback col %0d got %h exp %h", c, w, 24'h010101 * c); bad++;
      end
      cmp++;
    end
  endtask

  task automatic test_errors();
    logic [23:0] w, wi;
    int base;
    do_reset();
    base = cv_cnt;
    shift_word(24'hD2B4C6, 23);
    store(8'h01);
    if (bitcnt_err !== 1'b1) begin $display("FAIL short_bitcnt_err got %b exp 1", bitcnt_err); bad++; end
    cmp++;
    if (cv_cnt - base !== 1) begin $display("FAIL short_col_valid got %0d exp 1", cv_cnt - base); bad++; end
    cmp++;
    read_col(3'd0, w, wi);
    if (w !== 24'h52B4C6) begin $display("FAIL short_readback got %h exp 52b4c6", w); bad++; end
    cmp++;
    if (colsel_err !== 1'b0) begin $display("FAIL colsel_pre got %b exp 0", colsel_err); bad++; end
    cmp++;
    base = cv_cnt;
    store(8'h00);
    if (colsel_err !== 1'b1) begin $display("FAIL colsel_zero got %b exp 1", colsel_err); bad++; end
    cmp++;
    store(8'h11);
    if (cv_cnt - base !== 0) begin $display("FAIL colsel_no_valid got %0d exp 0", cv_cnt - base); bad++; end
    cmp++;
    oe_n = 1'b1;
    store(8'h02);
    oe_n = 1'b0;
    if (blank_seen !== 1'b1 || cv_cnt - base !== 1) begin
      $display("FAIL blank_store got blank=%b valid=%0d exp 1 1", blank_seen, cv_cnt - base); bad++;
    end
    cmp++;
  endtask

  task automatic test_same_cycle();
    logic [23:0] w, wi;
    do_reset();
    shift_word(24'hC3A5F0, 24);
    col_sel = 8'h04;
    ds = 1'b1;
    repeat (2) @(negedge clk);
    sh_cp = 1'b1;
    st_cp = 1'b1;
    repeat (3) @(negedge clk);
    sh_cp = 1'b0;
    st_cp = 1'b0;
    repeat (6) @(negedge clk);
    shift_word(24'h001234, 23);
    store(8'h20);
    read_col(3'd2, w, wi);
    if (w !== 24'hC3A5F0) begin $display("FAIL same_cycle_pre_word got %h exp c3a5f0", w); bad++; end
    cmp++;
    read_col(3'd5, w, wi);
    if (w !== 24'h801234) begin $display("FAIL same_cycle_next_word got %h exp 801234", w); bad++; end
    cmp++;
    if (bitcnt_err !== 1'b0) begin $display("FAIL same_cycle_bitcnt got %b exp 0", bitcnt_err); bad++; end
    cmp++;
  endtask

  task automatic test_sr_reset();
    logic [23:0] w, wi;
    do_reset();
    shift_word(24'hFFFFFF, 10);
    sr_reset_n = 1'b0;
    repeat (6) @(negedge clk);
    sr_reset_n = 1'b1;
    repeat (4) @(negedge clk);
    shift_word(24'hFFFFFF, 24);
    store(8'h40);
    read_col(3'd6, w, wi);
    if (w !== 24'hFFFFFF) begin $display("FAIL srreset_word got %h exp ffffff", w); bad++; end
    cmp++;
    if (wi !== 24'h000000) begin $display("FAIL srreset_inverted_word got %h exp 000000", wi); bad++; end
    cmp++;
    if (bitcnt_err !== 1'b0 || be2 !== 1'b0) begin
      $display("FAIL srreset_bitcnt got %b/%b exp 0/0", bitcnt_err, be2); bad++;
    end
    cmp++;
  endtask

  task automatic test_midframe_reset();
    int base;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      shift_word({3{8'hF0 | 8'(c)}}, 24);
      store(8'd1 << c);
    end
    shift_word(24'hABCDEF, 7);
    rd_col = 3'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (col_idx !== 3'd0 || rd_red !== 8'd0 || frame_cnt !== 16'd0) begin
      $display("FAIL midframe_reset_outputs got idx=%0d red=%h cnt=%0d exp 0 0 0", col_idx, rd_red, frame_cnt);
      bad++;
    end
    cmp++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = fd_cnt;
    for (int c = 0; c < 8; c++) begin
      shift_word(24'h111111 * c, 24);
      store(8'd1 << c);
    end
    if (frame_cnt !== 16'd1 || fd_cnt - base !== 1) begin
      $display("FAIL midframe_refill got cnt=%0d pulses=%0d exp 1 1", frame_cnt, fd_cnt - base); bad++;
    end
    cmp++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_errors();
    test_same_cycle();
    test_sr_reset();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
